reg_wb_arbiter: RTL
===================

Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Port A: the in-order pipeline writeback stage. It has priority and no backpressure.
  - Port B: a multi-cycle unit such as a divider or slow load path. It uses a valid/ready handshake.
- B results wait in a one-entry holding buffer.
- A starvation counter can freeze the pipeline for one cycle so B drains.
- Drives the register file's w_reg/w_data/RegWrite inputs through registered outputs.
- Exports the pending-buffer destination so the hazard unit can stall readers.

Parameters:
- DATA_W, 64: data word width (matches the machine word).
- MAX_WAIT, 4: cycles a buffered B write may be denied before a forced slot; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_wen  in  1  pipeline writeback request
- a_reg  in  5  pipeline destination register
- a_data  in  DATA_W  pipeline writeback data
- b_valid  in  1  multi-cycle unit result valid
- b_reg  in  5  multi-cycle unit destination register
- b_data  in  DATA_W  multi-cycle unit result data
- b_ready  out  1  holding buffer can accept (combinational, = ~hb_valid)
- stall_a  out  1  freeze pipeline writeback this cycle (combinational, = state==FORCE)
- RegWrite  out  1  register-file write enable (registered)
- w_reg  out  5  register-file write address (registered)
- w_data  out  DATA_W  register-file write data (registered)
- pend_valid  out  1  holding buffer occupied (registered)
- pend_reg  out  5  destination held in buffer (registered)

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; hb_valid, wait_cnt, RegWrite, w_reg, w_data, pend_valid and pend_reg all clear to 0.
  - This discards any buffered B write.
  - Outputs b_ready=1 and stall_a=0.
- Write to register 31 (XZR) from either source counts as "no write".
  - It is never forwarded to RegWrite.
  - A B write to 31 is accepted and discarded without entering the buffer.
- a_act = a_wen & (a_reg != 31).
- States and transitions:
  - IDLE (hb empty): a b_valid & b_ready handshake with b_reg != 31 loads the buffer (reg, data) and moves to PEND. Port output follows A.
  - PEND (hb full):
    - If !a_act: hb is written, hb_valid clears, next state IDLE.
    - If a_act and a_reg == hb_reg: A writes, the hb entry is dropped because A is younger, next state IDLE.
    - Otherwise A writes and wait_cnt increments. When wait_cnt == MAX_WAIT-1 in that cycle, next state is FORCE.
  - FORCE: stall_a=1. hb is written regardless of a_wen. The pipeline holds its writeback and re-presents it next cycle. Next state IDLE, wait_cnt clears.
- B cannot be accepted in the same cycle the buffer drains. b_ready depends only on registered hb_valid, so there is no combinational path from b_valid to b_ready.
- Output latency:
  - The granted write appears on RegWrite/w_reg/w_data one cycle after its grant cycle.
  - RegWrite=0 on cycles with no grant; w_reg and w_data hold their last values.
- pend_valid/pend_reg mirror the buffer contents after each clock edge.
- Invariant: at most one RegWrite per cycle. A and B are never both written in one cycle.

Test Plan:
- Reset, then A alone: a_wen=1, a_reg=5, a_data=0x11 for 3 cycles -> RegWrite=1, w_reg=5, w_data=0x11 from cycle+1; b_ready=1 throughout; stall_a=0.
- B into idle port: b_valid=1, b_reg=7, b_data=0xAB with a_wen=0 -> pend_valid=1 after edge 1; RegWrite=1, w_reg=7, w_data=0xAB after edge 2; b_ready low only during cycle 2.
- Starvation with MAX_WAIT=4: B buffered to reg 9 while A writes reg 3 every cycle -> stall_a=1 on the 5th cycle after the buffer loads; reg 9 written in the following output cycle; A's pending write to reg 3 issues the cycle after.
- Same-destination override: buffer holds reg 12 = 0x1; A writes reg 12 = 0x2 -> only 0x2 appears on the port; pend_valid=0 next cycle; no later write of 0x1.
- XZR filtering: a_reg=31 with a_wen=1 and B buffered to reg 4 -> buffer drains that cycle (w_reg=4); a B handshake with b_reg=31 -> RegWrite never asserted and pend_valid stays 0.
- Reset mid-operation: buffer full in PEND with wait_cnt=2, rst_n pulsed low -> all outputs 0 immediately, b_ready=1; after release there is no stale write to the buffered register.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - writeback sources, register-file write port and pending-buffer signals
interface reg_wb_arbiter_if #(
   parameter int DATA_W = 64
);
   logic              a_wen;
   logic [4:0]        a_reg;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic [4:0]        b_reg;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              stall_a;
   logic              RegWrite;
   logic [4:0]        w_reg;
   logic [DATA_W-1:0] w_data;
   logic              pend_valid;
   logic [4:0]        pend_reg;

   modport master (
      output a_wen, a_reg, a_data, b_valid, b_reg, b_data,
      input  b_ready, stall_a, RegWrite, w_reg, w_data, pend_valid, pend_reg
   );

   modport slave (
      input  a_wen, a_reg, a_data, b_valid, b_reg, b_data,
      output b_ready, stall_a, RegWrite, w_reg, w_data, pend_valid, pend_reg
   );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - two-source register-file writeback arbiter with one-entry B holding buffer
module reg_wb_arbiter #(
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input logic               clk,
   input logic               rst_n,
   reg_wb_arbiter_if.slave   bus
);
   localparam logic [4:0] XZR = 5'd31;

   typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

   state_t            state, state_n;
   logic              hb_valid;
   logic [4:0]        hb_reg;
   logic [DATA_W-1:0] hb_data;
   logic [3:0]        wait_cnt, cnt_n;
   logic              reg_write;
   logic [4:0]        w_reg_q;
   logic [DATA_W-1:0] w_data_q;

   logic              a_act;
   logic              hb_load, hb_clear;
   logic              grant;
   logic [4:0]        g_reg;
   logic [DATA_W-1:0] g_data;

   assign a_act = bus.a_wen & (bus.a_reg != XZR);

   assign bus.b_ready    = ~hb_valid;
   assign bus.stall_a    = (state == FORCE);
   assign bus.RegWrite   = reg_write;
   assign bus.w_reg      = w_reg_q;
   assign bus.w_data     = w_data_q;
   assign bus.pend_valid = hb_valid;
   assign bus.pend_reg   = hb_reg;

   always_comb begin
      state_n  = state;
      cnt_n    = wait_cnt;
      hb_load  = 1'b0;
      hb_clear = 1'b0;
      grant    = 1'b0;
      g_reg    = bus.a_reg;
      g_data   = bus.a_data;
      case (state)
         IDLE: begin
            grant = a_act;
            // A B write to XZR completes the handshake but is simply dropped
            if (bus.b_valid && !hb_valid && bus.b_reg != XZR) begin
               hb_load = 1'b1;
               state_n = PEND;
            end
         end
         PEND: begin
            if (!a_act) begin
               grant    = 1'b1;
               g_reg    = hb_reg;
               g_data   = hb_data;
               hb_clear = 1'b1;
               cnt_n    = 4'd0;
               state_n  = IDLE;
            end else if (bus.a_reg == hb_reg) begin
               // A is younger, so the buffered value for the same register is dead
               grant    = 1'b1;
               hb_clear = 1'b1;
               cnt_n    = 4'd0;
               state_n  = IDLE;
            end else begin
               grant = 1'b1;
               cnt_n = wait_cnt + 4'd1;
               if (wait_cnt == 4'(MAX_WAIT - 1))
                  state_n = FORCE;
            end
         end
         FORCE: begin
            grant    = 1'b1;
            g_reg    = hb_reg;
            g_data   = hb_data;
            hb_clear = 1'b1;
            cnt_n    = 4'd0;
            state_n  = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         hb_valid  <= 1'b0;
         hb_reg    <= 5'd0;
         hb_data   <= '0;
         reg_write <= 1'b0;
         w_reg_q   <= 5'd0;
         w_data_q  <= '0;
      end else begin
         state     <= state_n;
         wait_cnt  <= cnt_n;
         reg_write <= grant;
         if (grant) begin
            w_reg_q  <= g_reg;
            w_data_q <= g_data;
         end
         if (hb_load) begin
            hb_valid <= 1'b1;
            hb_reg   <= bus.b_reg;
            hb_data  <= bus.b_data;
         end else if (hb_clear) begin
            hb_valid <= 1'b0;
            hb_reg   <= 5'd0;
         end
      end
   end
endmodule
